// File: rtl/dso_minmax_decimator.sv
// Multi-channel peak-detect decimator: each window of n valid samples becomes one
// max/min record per channel (peak mode) or the window's first sample (sample mode).
module dso_minmax_decimator #(
    parameter int DW     = 8,
    parameter int NCH    = 4,
    parameter int CW     = 32,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW-1:0]     n,
    input  logic              mode,
    input  logic [NCH*DW-1:0] din,
    input  logic              din_valid,
    output logic [NCH*DW-1:0] dout_max,
    output logic [NCH*DW-1:0] dout_min,
    output logic              dout_valid
);

    logic [NCH*DW-1:0] s_data_q;
    logic              s_vld_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     n_l_q, n_l_d;
    logic              mode_l_q, mode_l_d;
    logic [NCH*DW-1:0] max_acc_q, max_acc_d;
    logic [NCH*DW-1:0] min_acc_q, min_acc_d;
    logic [NCH*DW-1:0] dout_max_q, dout_max_d;
    logic [NCH*DW-1:0] dout_min_q, dout_min_d;
    logic              dout_valid_q, dout_valid_d;

    logic [CW-1:0]     n_eff;
    logic [CW-1:0]     n_cur;
    logic [CW-1:0]     cnt_inc;
    logic              win_start;
    logic              win_close;
    logic              mode_cur;

    function automatic logic greater(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (SIGNED != 0) greater = ($signed(a) > $signed(b));
        else             greater = (a > b);
    endfunction

    // The sample that opens a window must already obey the ratio and mode it latches,
    // so a window of one closes on its own opening sample.
    assign n_eff     = (n == '0) ? CW'(1) : n;
    assign win_start = (cnt_q == '0);
    assign n_cur     = win_start ? n_eff : n_l_q;
    assign mode_cur  = win_start ? mode : mode_l_q;
    assign cnt_inc   = cnt_q + CW'(1);
    assign win_close = s_vld_q && (cnt_inc == n_cur);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path infers a latch.
        cnt_d        = cnt_q;
        n_l_d        = n_l_q;
        mode_l_d     = mode_l_q;
        max_acc_d    = max_acc_q;
        min_acc_d    = min_acc_q;
        dout_max_d   = dout_max_q;
        dout_min_d   = dout_min_q;
        dout_valid_d = 1'b0;

        if (s_vld_q) begin
            if (win_start) begin
                n_l_d    = n_eff;
                mode_l_d = mode;
            end
            cnt_d = win_close ? '0 : cnt_inc;

            for (int c = 0; c < NCH; c++) begin
                if (win_start) begin
                    max_acc_d[c*DW +: DW] = s_data_q[c*DW +: DW];
                    min_acc_d[c*DW +: DW] = s_data_q[c*DW +: DW];
                end else if (!mode_cur) begin
                    if (greater(s_data_q[c*DW +: DW], max_acc_q[c*DW +: DW]))
                        max_acc_d[c*DW +: DW] = s_data_q[c*DW +: DW];
                    if (greater(min_acc_q[c*DW +: DW], s_data_q[c*DW +: DW]))
                        min_acc_d[c*DW +: DW] = s_data_q[c*DW +: DW];
                end
            end

            // The closing sample's contribution is already folded into the _d values.
            if (win_close) begin
                dout_max_d   = max_acc_d;
                dout_min_d   = min_acc_d;
                dout_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: data registers are cleared too, so outputs read 0 after reset instead of stale peaks.
        if (rst) begin
            s_data_q     <= '0;
            s_vld_q      <= 1'b0;
            cnt_q        <= '0;
            n_l_q        <= '0;
            mode_l_q     <= 1'b0;
            max_acc_q    <= '0;
            min_acc_q    <= '0;
            dout_max_q   <= '0;
            dout_min_q   <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            s_data_q     <= din;
            s_vld_q      <= din_valid;
            cnt_q        <= cnt_d;
            n_l_q        <= n_l_d;
            mode_l_q     <= mode_l_d;
            max_acc_q    <= max_acc_d;
            min_acc_q    <= min_acc_d;
            dout_max_q   <= dout_max_d;
            dout_min_q   <= dout_min_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout_max   = dout_max_q;
    assign dout_min   = dout_min_q;
    assign dout_valid = dout_valid_q;

endmodule
